// File: rtl/cm0_debug_memap.sv
// Debug memory-access port master: CSW/TAR/DRW register file driving single
// transfers on the debug slave channel, with TAR auto-increment and sticky error.
module cm0_debug_memap (
  input  logic        DCLK,
  input  logic        DBGRESETn,
  input  logic        APREQ,
  input  logic        APWRITE,
  input  logic [1:0]  APADDR,
  input  logic [31:0] APWDATA,
  output logic [31:0] APRDATA,
  output logic        APACK,
  output logic        APERR,
  output logic [1:0]  SLVTRANS,
  output logic [1:0]  SLVSIZE,
  output logic        SLVWRITE,
  output logic [31:0] SLVADDR,
  output logic [31:0] SLVWDATA,
  input  logic [31:0] SLVRDATA,
  input  logic        SLVREADY,
  input  logic        SLVRESP
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state;
  logic [1:0]  size;
  logic        inc_en;
  logic        sticky_err;
  logic [31:0] tar;
  logic [31:0] csw_value;
  logic [31:0] tar_step;

  always_comb begin
    csw_value = {24'h0, sticky_err, (state == ADDR) || (state == DATA),
                 1'b0, inc_en, 2'b00, size};
    case (size)
      2'b00:   tar_step = 32'd1;
      2'b01:   tar_step = 32'd2;
      default: tar_step = 32'd4;
    endcase
  end

  // Address-phase qualifier is decoded from state so reset kills it immediately.
  assign SLVTRANS = (state == ADDR) ? 2'b10 : 2'b00;
  assign SLVADDR  = tar;
  assign SLVSIZE  = size;

  always_ff @(posedge DCLK or negedge DBGRESETn) begin
    if (!DBGRESETn) begin
      state      <= IDLE;
      size       <= 2'b10;
      inc_en     <= 1'b0;
      sticky_err <= 1'b0;
      tar        <= 32'h0;
      SLVWRITE   <= 1'b0;
      SLVWDATA   <= 32'h0;
      APACK      <= 1'b0;
      APERR      <= 1'b0;
      APRDATA    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (APREQ) begin
            case (APADDR)
              2'd0: begin
                if (APWRITE) begin
                  size   <= (APWDATA[1:0] == 2'b11) ? 2'b10 : APWDATA[1:0];
                  inc_en <= ~APWDATA[5] & APWDATA[4];
                  if (APWDATA[7]) sticky_err <= 1'b0;
                end else begin
                  APRDATA <= csw_value;
                end
              end
              2'd1: begin
                if (APWRITE) tar <= APWDATA;
                else         APRDATA <= tar;
              end
              2'd3: begin
                SLVWRITE <= APWRITE;
                SLVWDATA <= APWDATA;
              end
              default: ;
            endcase
            // A DRW access only reaches the slave when no error is pending.
            if (APADDR == 2'd3 && !sticky_err) begin
              state <= ADDR;
            end else begin
              state <= DONE;
              APACK <= 1'b1;
              APERR <= (APADDR == 2'd3);
            end
          end
        end
        ADDR: begin
          if (SLVREADY) state <= DATA;
        end
        DATA: begin
          if (SLVREADY) begin
            state   <= DONE;
            APACK   <= 1'b1;
            APERR   <= SLVRESP;
            APRDATA <= SLVWRITE ? 32'h0 : SLVRDATA;
            if (SLVRESP)     sticky_err <= 1'b1;
            else if (inc_en) tar <= tar + tar_step;
          end
        end
        default: begin
          state   <= IDLE;
          APACK   <= 1'b0;
          APERR   <= 1'b0;
          APRDATA <= 32'h0;
        end
      endcase
    end
  end

endmodule
